// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared opcodes, ALU classes, muldiv FSM states and stall codes for the EX stage.
package ex_stage_pkg;
    localparam int XLEN = 32;
    localparam int STALL_EX = 3;
    localparam logic STOP = 1'b1;
    localparam logic NO_STOP = 1'b0;
    typedef enum logic [2:0] {
        ALU_NOP, ALU_LOGIC, ALU_SHIFT, ALU_ARITH, ALU_UPPER, ALU_JUMP, ALU_MULDIV
    } alusel_e;
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
    localparam logic [6:0] OPC_OP = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] EXE_FUNC7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4, F3_SR = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;
    localparam logic [2:0] F3_MUL = 3'd0, F3_MULH = 3'd1, F3_MULHSU = 3'd2, F3_MULHU = 3'd3;
    localparam logic [2:0] F3_DIV = 3'd4, F3_DIVU = 3'd5, F3_REM = 3'd6, F3_REMU = 3'd7;
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M engine, radix-2 shift-add multiply and restoring divide, one bit per cycle.
module muldiv_iter
    import ex_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            hold,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    md_state_e state, state_n;
    logic [4:0] cnt;
    logic [2:0] op_q;
    logic [31:0] hi, lo, d, hi_n, lo_n, res_n, res_special, sub, q, r;
    logic neg_q, neg_r, sa, sb, an, bn, div0, ovf, special, ge;
    logic [32:0] msum, shl;
    logic [63:0] prod;
    always_comb begin
        sa = op == F3_MULHU ? 1'b0 : op[2] ? ~op[0] : 1'b1;
        sb = op[2] ? ~op[0] : ~op[1];
        an = sa & a[31];
        bn = sb & b[31];
        div0 = op[2] && b == '0;
        ovf = op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        special = div0 | ovf;
        // overflow case has a == 0x80000000, which is exactly the quotient
        res_special = div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
        msum = lo[0] ? {1'b0, hi} + {1'b0, d} : {1'b0, hi};
        shl = {hi, lo[31]};
        ge = shl >= {1'b0, d};
        sub = shl[31:0] - d;
        hi_n = op_q[2] ? (ge ? sub : shl[31:0]) : msum[32:1];
        lo_n = op_q[2] ? {lo[30:0], ge} : {msum[0], lo[31:1]};
        prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        q = neg_q ? -lo_n : lo_n;
        r = neg_r ? -hi_n : hi_n;
        res_n = op_q[2] ? (op_q[1] ? r : q) : (op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
        state_n = state == MD_IDLE ? (start ? (special ? MD_DONE : MD_BUSY) : MD_IDLE)
                : state == MD_BUSY ? (cnt == 5'd31 ? MD_DONE : MD_BUSY)
                : (hold ? MD_DONE : MD_IDLE);
        busy = (state == MD_IDLE && start) || state == MD_BUSY;
        done = state == MD_DONE;
    end
    always_ff @(posedge clk)
        if (!rst) state <= MD_IDLE;
        else state <= state_n;
    always_ff @(posedge clk)
        if (!rst) begin
            {cnt, op_q, hi, lo, d, neg_q, neg_r, result} <= '0;
        end else if (state == MD_IDLE && start) begin
            cnt <= '0;
            op_q <= op;
            neg_q <= an ^ bn;
            neg_r <= an;
            hi <= '0;
            lo <= op[2] ? mag(a, an) : mag(b, bn);
            d <= op[2] ? mag(b, bn) : mag(a, an);
            result <= res_special;
        end else if (state == MD_BUSY) begin
            hi <= hi_n;
            lo <= lo_n;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) result <= res_n;
        end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32IM execute stage; combinational ALU/link path plus stalling iterative mul/div.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      stall,
    input  alusel_e         alusel_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      func3_i,
    input  logic [6:0]      func7_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    input  logic [XLEN-1:0] link_addr_i,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            stallreq_o
);
    logic is_m, is_sub, md_busy, md_done, unused;
    logic [4:0] shamt;
    logic [XLEN-1:0] md_result, alu_res, sra_res, base_res;
    assign unused = ^{stall[5:4], stall[2:0], md_done};
    assign is_m = alusel_i != ALU_NOP && opcode_i == OPC_OP && func7_i == EXE_FUNC7_MULDIV;
    muldiv_iter u_muldiv (
        .clk(clk), .rst(rst), .start(is_m), .hold(stall[STALL_EX] == STOP),
        .op(func3_i), .a(reg1_i), .b(reg2_i),
        .busy(md_busy), .done(md_done), .result(md_result)
    );
    always_comb begin
        shamt = reg2_i[4:0];
        // only register-register ops carry SUB; OP-IMM's func7 field is immediate bits
        is_sub = opcode_i == OPC_OP && func7_i[5];
        sra_res = $signed(reg1_i) >>> shamt;
        case (func3_i)
            F3_ADD:  base_res = is_sub ? reg1_i - reg2_i : reg1_i + reg2_i;
            F3_SLL:  base_res = reg1_i << shamt;
            F3_SLT:  base_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
            F3_SLTU: base_res = {31'b0, reg1_i < reg2_i};
            F3_XOR:  base_res = reg1_i ^ reg2_i;
            F3_SR:   base_res = func7_i[5] ? sra_res : reg1_i >> shamt;
            F3_OR:   base_res = reg1_i | reg2_i;
            default: base_res = reg1_i & reg2_i;
        endcase
        alu_res = opcode_i == OPC_LUI ? reg2_i : opcode_i == OPC_AUIPC ? reg1_i + reg2_i : base_res;
        wdata_o = (!rst || alusel_i == ALU_NOP) ? '0
                : alusel_i == ALU_JUMP ? link_addr_i
                : is_m ? md_result : alu_res;
        wd_o = rst ? wd_i : '0;
        wreg_o = rst && wreg_i && alusel_i != ALU_NOP;
        stallreq_o = rst && md_busy;
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven ALU vectors and M-op vectors, plus hand sequences for reset, hold and back-to-back.
module tb_ex_stage;
    import ex_stage_pkg::*;
    logic clk = 1'b0, rst = 1'b0, wreg = 1'b0;
    logic [5:0] stall = '0;
    alusel_e alusel = ALU_NOP;
    logic [6:0] opcode = '0, func7 = '0;
    logic [2:0] func3 = '0;
    logic [31:0] reg1 = '0, reg2 = '0, link = '0;
    logic [4:0] wd = '0;
    logic [4:0] wd_o;
    logic wreg_o, stallreq_o;
    logic [31:0] wdata_o;
    int checks = 0, errors = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .alusel_i(alusel), .opcode_i(opcode),
        .func3_i(func3), .func7_i(func7), .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd),
        .wreg_i(wreg), .link_addr_i(link), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        alusel_e sel; logic [6:0] opc; logic [2:0] f3; logic [6:0] f7;
        logic [31:0] a, b, lnk; logic [4:0] wd; logic wreg;
        logic [31:0] exp; logic exp_wreg;
    } alu_vec_t;
    typedef struct { logic [2:0] f3; logic [31:0] a, b, exp; int cycles; } m_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        alusel = ALU_MULDIV; opcode = OPC_OP; func7 = EXE_FUNC7_MULDIV;
        func3 = f3; reg1 = a; reg2 = b; wd = 5'd9; wreg = 1'b1;
    endtask

    task automatic bubble();
        alusel = ALU_NOP; wreg = 1'b0; opcode = '0; func7 = '0;
    endtask

    // counts stall cycles from the issue cycle until DONE, bounded
    task automatic wait_done(output int n);
        n = 0;
        #1;
        while (stallreq_o && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        alu_vec_t av[$];
        m_vec_t mv[$];
        int n;
        av.push_back('{ALU_ARITH, OPC_OP,     F3_ADD,  7'h00, 32'd5,        32'd7,        32'd0,     5'd3,  1'b1, 32'd12,       1'b1});
        av.push_back('{ALU_ARITH, OPC_OP,     F3_ADD,  7'h20, 32'd5,        32'd7,        32'd0,     5'd4,  1'b1, 32'hFFFFFFFE, 1'b1});
        av.push_back('{ALU_ARITH, OPC_OP_IMM, F3_ADD,  7'h20, 32'd5,        32'd7,        32'd0,     5'd5,  1'b1, 32'd12,       1'b1});
        av.push_back('{ALU_SHIFT, OPC_OP,     F3_SLL,  7'h00, 32'd1,        32'h23,       32'd0,     5'd6,  1'b1, 32'd8,        1'b1});
        av.push_back('{ALU_SHIFT, OPC_OP,     F3_SR,   7'h00, 32'h80000000, 32'd4,        32'd0,     5'd7,  1'b1, 32'h08000000, 1'b1});
        av.push_back('{ALU_SHIFT, OPC_OP,     F3_SR,   7'h20, 32'h80000000, 32'd4,        32'd0,     5'd8,  1'b1, 32'hF8000000, 1'b1});
        av.push_back('{ALU_ARITH, OPC_OP,     F3_SLT,  7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,     5'd9,  1'b1, 32'd1,        1'b1});
        av.push_back('{ALU_ARITH, OPC_OP,     F3_SLTU, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,     5'd10, 1'b1, 32'd0,        1'b1});
        av.push_back('{ALU_LOGIC, OPC_OP,     F3_XOR,  7'h00, 32'h0000F0F0, 32'h0000FF00, 32'd0,     5'd11, 1'b1, 32'h00000FF0, 1'b1});
        av.push_back('{ALU_LOGIC, OPC_OP,     F3_OR,   7'h00, 32'h000000F0, 32'h0000000F, 32'd0,     5'd12, 1'b1, 32'h000000FF, 1'b1});
        av.push_back('{ALU_LOGIC, OPC_OP,     F3_AND,  7'h00, 32'h0000F0F0, 32'h0000FF00, 32'd0,     5'd13, 1'b1, 32'h0000F000, 1'b1});
        av.push_back('{ALU_UPPER, OPC_LUI,    3'd0,    7'h00, 32'd0,        32'h12345000, 32'd0,     5'd14, 1'b1, 32'h12345000, 1'b1});
        av.push_back('{ALU_UPPER, OPC_AUIPC,  3'd0,    7'h00, 32'h1000,     32'h2000,     32'd0,     5'd15, 1'b1, 32'h3000,     1'b1});
        av.push_back('{ALU_JUMP,  OPC_JAL,    3'd0,    7'h00, 32'd0,        32'd0,        32'h104,   5'd1,  1'b1, 32'h104,      1'b1});
        av.push_back('{ALU_JUMP,  OPC_JALR,   3'd0,    7'h00, 32'h55,       32'h4,        32'h208,   5'd2,  1'b1, 32'h208,      1'b1});
        av.push_back('{ALU_NOP,   OPC_OP,     F3_ADD,  7'h00, 32'd5,        32'd7,        32'd0,     5'd3,  1'b1, 32'd0,        1'b0});
        av.push_back('{ALU_ARITH, OPC_OP,     F3_ADD,  7'h00, 32'd1,        32'd1,        32'd0,     5'd16, 1'b0, 32'd2,        1'b0});
        mv.push_back('{F3_MUL,    32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 33});
        mv.push_back('{F3_MULHU,  32'hFFFFFFFF, 32'd3,        32'h00000002, 33});
        mv.push_back('{F3_MULH,   32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF, 33});
        mv.push_back('{F3_MULHSU, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF, 33});
        mv.push_back('{F3_MULHSU, 32'd2,        32'hFFFFFFFF, 32'h00000001, 33});
        mv.push_back('{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33});
        mv.push_back('{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        mv.push_back('{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        mv.push_back('{F3_DIVU,   32'd100,      32'd7,        32'd14,       33});
        mv.push_back('{F3_REMU,   32'd100,      32'd7,        32'd2,        33});
        mv.push_back('{F3_DIV,    32'h80000000, 32'd2,        32'hC0000000, 33});
        mv.push_back('{F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1});
        mv.push_back('{F3_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1});
        mv.push_back('{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
        mv.push_back('{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});

        issue_m(F3_MUL, 32'd6, 32'd7);
        repeat (2) @(negedge clk);
        #1;
        check("reset stallreq", {31'b0, stallreq_o}, 32'd0);
        check("reset wdata", wdata_o, 32'd0);
        check("reset wd", {27'b0, wd_o}, 32'd0);
        check("reset wreg", {31'b0, wreg_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bubble();

        foreach (av[i]) begin
            @(negedge clk);
            alusel = av[i].sel; opcode = av[i].opc; func3 = av[i].f3; func7 = av[i].f7;
            reg1 = av[i].a; reg2 = av[i].b; link = av[i].lnk; wd = av[i].wd; wreg = av[i].wreg;
            #1;
            check($sformatf("alu%0d wdata", i), wdata_o, av[i].exp);
            check($sformatf("alu%0d wd", i), {27'b0, wd_o}, {27'b0, av[i].wd});
            check($sformatf("alu%0d wreg", i), {31'b0, wreg_o}, {31'b0, av[i].exp_wreg});
            check($sformatf("alu%0d stallreq", i), {31'b0, stallreq_o}, 32'd0);
        end
        @(negedge clk);
        bubble();

        foreach (mv[i]) begin
            @(negedge clk);
            issue_m(mv[i].f3, mv[i].a, mv[i].b);
            wait_done(n);
            check($sformatf("m%0d cycles", i), n, mv[i].cycles);
            check($sformatf("m%0d result", i), wdata_o, mv[i].exp);
            check($sformatf("m%0d wreg", i), {31'b0, wreg_o}, 32'd1);
            check($sformatf("m%0d wd", i), {27'b0, wd_o}, 32'd9);
            bubble();
        end

        // back-to-back: next M op presented during DONE
        @(negedge clk);
        issue_m(F3_DIVU, 32'd100, 32'd7);
        wait_done(n);
        check("b2b first", wdata_o, 32'd14);
        issue_m(F3_REMU, 32'd100, 32'd7);
        @(negedge clk);
        wait_done(n);
        check("b2b cycles", n, 32'd33);
        check("b2b second", wdata_o, 32'd2);
        bubble();

        // reset in the middle of BUSY
        @(negedge clk);
        issue_m(F3_MUL, 32'hFFFFFFFF, 32'd3);
        repeat (10) @(negedge clk);
        check("busy stallreq", {31'b0, stallreq_o}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst stallreq", {31'b0, stallreq_o}, 32'd0);
        check("midrst wdata", wdata_o, 32'd0);
        check("midrst wd", {27'b0, wd_o}, 32'd0);
        check("midrst wreg", {31'b0, wreg_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bubble();
        #1;
        check("postrst stallreq", {31'b0, stallreq_o}, 32'd0);
        @(negedge clk);
        issue_m(F3_MUL, 32'd6, 32'd7);
        wait_done(n);
        check("postrst cycles", n, 32'd33);
        check("postrst mul", wdata_o, 32'd42);
        bubble();

        // DONE held by a downstream stop
        @(negedge clk);
        issue_m(F3_MUL, 32'h12345678, 32'h10);
        wait_done(n);
        check("hold result", wdata_o, 32'h23456780);
        stall = 6'b001111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d wdata", k), wdata_o, 32'h23456780);
            check($sformatf("hold%0d stallreq", k), {31'b0, stallreq_o}, 32'd0);
        end
        stall = '0;
        @(negedge clk);
        check("release restart", {31'b0, stallreq_o}, 32'd1);
        wait_done(n);
        check("release cycles", n, 32'd33);
        check("release result", wdata_o, 32'h23456780);
        bubble();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
